// File: rtl/shift_agc_ctrl.sv
// shift_agc_ctrl: automatic shift-select controller for the 32-to-8 bit slice shifter
// Ports: clk/rst (sync, active-high); enable/manual/manual_sh select the mode (manual wins);
// data_in/valid_data_in are the sample stream, forwarded one cycle later on data_out/valid_data_out;
// sh_amt drives the shifter (slice [2*sh+7:2*sh]); sh_update pulses when sh_amt changes;
// clip flags a forwarded sample that did not fit the shift in force when it arrived.
module shift_agc_ctrl #(
    parameter int WIN_LOG2      = 8,
    parameter int DECAY_WINDOWS = 4,
    parameter int MAX_SH        = 12,
    parameter int INIT_SH       = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        manual,
    input  logic [3:0]  manual_sh,
    input  logic [31:0] data_in,
    input  logic        valid_data_in,
    output logic [31:0] data_out,
    output logic        valid_data_out,
    output logic [3:0]  sh_amt,
    output logic        sh_update,
    output logic        clip
);
    localparam int DW = DECAY_WINDOWS > 1 ? $clog2(DECAY_WINDOWS) : 1;
    localparam logic [3:0] L_MAX = 4'(MAX_SH);
    localparam logic [3:0] L_INIT = 4'(INIT_SH);
    localparam logic [DW-1:0] L_DECAY_LAST = DW'(DECAY_WINDOWS - 1);

    typedef enum logic [1:0] {IDLE, MANUAL, TRACK} state_t;

    state_t              r_state, w_state_next;
    logic [WIN_LOG2-1:0] r_win, w_win_cur, w_win_next;
    logic [30:0]         r_peak, w_peak_cur, w_peak_next, w_mag, w_acc;
    logic [DW-1:0]       r_decay, w_decay_cur, w_decay_next;
    logic [3:0]          r_sh, w_sh_next, w_target_raw, w_target, w_man_sh;
    logic [4:0]          w_lead;
    logic [5:0]          w_thr;
    logic [31:0]         r_data;
    logic                r_valid, r_upd, r_clip, w_clip_next, w_over, w_last;

    // One's complement magnitude: the top set bit matches the bit count the
    // two's-complement slice needs, and ~(-2^31) cannot overflow.
    always_comb begin
        w_mag = data_in[31] ? ~data_in[30:0] : data_in[30:0];
        w_thr = 6'd7 + {1'b0, r_sh, 1'b0};
        w_over = |(w_mag >> w_thr);
        w_man_sh = manual_sh > L_MAX ? L_MAX : manual_sh;
    end

    // Window bookkeeping only survives while TRACK persists; any entry starts fresh.
    always_comb begin
        w_win_cur = r_state == TRACK ? r_win : '0;
        w_peak_cur = r_state == TRACK ? r_peak : '0;
        w_decay_cur = r_state == TRACK ? r_decay : '0;
        w_acc = w_peak_cur | w_mag;
        w_last = valid_data_in && (w_win_cur == '1);
    end

    // Leading-one position of the accumulated peak, including this sample.
    always_comb begin
        w_lead = '0;
        for (int i = 0; i < 31; i++)
            if (w_acc[i]) w_lead = 5'(i);
        w_target_raw = w_lead <= 5'd6 ? 4'd0 : 4'((w_lead - 5'd5) >> 1);
        w_target = w_target_raw > L_MAX ? L_MAX : w_target_raw;
    end

    always_comb begin
        w_state_next = manual ? MANUAL : (enable ? TRACK : IDLE);
        w_win_next = '0;
        w_peak_next = '0;
        w_decay_next = '0;
        w_sh_next = r_sh;
        w_clip_next = 1'b0;
        if (w_state_next == MANUAL) begin
            w_sh_next = w_man_sh;
        end else if (w_state_next == TRACK) begin
            w_win_next = w_win_cur;
            w_peak_next = w_peak_cur;
            w_decay_next = w_decay_cur;
            if (valid_data_in) begin
                w_win_next = w_win_cur + 1'b1;
                w_peak_next = w_last ? '0 : w_acc;
                w_clip_next = w_over;
                if (w_last) begin
                    // Attack jumps straight to the target; decay steps down by one
                    // only after enough consecutive under-range windows.
                    if (w_target > r_sh) begin
                        w_sh_next = w_target;
                        w_decay_next = '0;
                    end else if (w_target == r_sh) begin
                        w_decay_next = '0;
                    end else if (w_decay_cur == L_DECAY_LAST) begin
                        w_sh_next = r_sh - 1'b1;
                        w_decay_next = '0;
                    end else begin
                        w_decay_next = w_decay_cur + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_win <= '0;
            r_peak <= '0;
            r_decay <= '0;
            r_sh <= L_INIT;
            r_upd <= 1'b0;
            r_clip <= 1'b0;
            r_data <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_win <= w_win_next;
            r_peak <= w_peak_next;
            r_decay <= w_decay_next;
            r_sh <= w_sh_next;
            r_upd <= w_sh_next != r_sh;
            r_clip <= w_clip_next;
            r_data <= data_in;
            r_valid <= valid_data_in;
        end
    end

    assign data_out = r_data;
    assign valid_data_out = r_valid;
    assign sh_amt = r_sh;
    assign sh_update = r_upd;
    assign clip = r_clip;
endmodule
